// File: rtl/mx11_regbank.sv
// mx11_regbank: 16 x 8-bit register bank with an execution-unit write port
// and a fetch write port, arbitrated with a starvation limit on fetch.
module mx11_regbank #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [15:0][7:0] reg_line,
  input  logic [15:0][7:0] data_line,
  input  logic [7:0]       load_addr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       fetch_data,
  input  logic [3:0]       fetch_dst,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  output logic             bad_addr
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] sc;
  logic       starve;
  logic       wr_acc;
  logic       fetch_acc;
  logic [3:0] prefix;
  logic [3:0] dst;
  logic       wr_reg;
  logic       wr_bad;

  assign prefix = load_addr[7:4];
  assign dst    = load_addr[3:0];
  assign starve = (sc == LIM);

  assign wr_ready    = !rst && !(fetch_valid && starve);
  assign fetch_ready = !rst && (!wr_valid || starve);

  // The two ready terms are mutually exclusive when both sides request.
  assign wr_acc    = wr_valid && wr_ready;
  assign fetch_acc = fetch_valid && fetch_ready;

  always_comb begin
    wr_reg = 1'b0;
    wr_bad = 1'b0;
    unique case (1'b1)
      (prefix == 4'h1): wr_reg = 1'b1;
      (prefix == 4'h0): wr_reg = (dst == 4'd7);
      default:          wr_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_line <= '0;
      sc       <= '0;
      bad_addr <= 1'b0;
    end else begin
      if (fetch_acc) begin
        reg_line[fetch_dst] <= fetch_data;
      end else if (wr_acc && wr_reg) begin
        reg_line[dst] <= data_line[dst];
      end
      if (wr_acc && wr_bad) begin
        bad_addr <= 1'b1;
      end
      // A pending, unaccepted fetch counts up and saturates at the limit.
      if (!fetch_valid || fetch_acc) begin
        sc <= '0;
      end else if (!starve) begin
        sc <= sc + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mx11_regbank.sv
// Scoreboard bench for mx11_regbank: stimulus pushes expected responses,
// a monitor pops them and compares against the DUT.
module tb_mx11_regbank;

  localparam int LIM = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0][7:0] reg_line;
  logic [15:0][7:0] data_line;
  logic [7:0]       load_addr;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       fetch_data;
  logic [3:0]       fetch_dst;
  logic             fetch_valid;
  logic             fetch_ready;
  logic             bad_addr;

  mx11_regbank #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk),
    .rst(rst),
    .reg_line(reg_line),
    .data_line(data_line),
    .load_addr(load_addr),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .fetch_data(fetch_data),
    .fetch_dst(fetch_dst),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               wr_rdy;
    bit               f_rdy;
    logic [15:0][7:0] regs;
    bit               bad;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  // Reference state: plain byte array, waited-cycle count, sticky flag.
  byte unsigned m_regs[16];
  int           waited;
  bit           m_bad;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0][7:0] rand_line();
    logic [15:0][7:0] l;
    for (int i = 0; i < 16; i++) l[i] = 8'($urandom);
    return l;
  endfunction

  function automatic logic [15:0][7:0] model_line();
    logic [15:0][7:0] l;
    for (int i = 0; i < 16; i++) l[i] = m_regs[i];
    return l;
  endfunction

  task automatic cyc(input bit r, input bit wv, input logic [7:0] la,
                     input logic [15:0][7:0] dl, input bit fv,
                     input logic [7:0] fd, input logic [3:0] fdst);
    exp_t e;
    bit   fetch_turn;
    int   p;
    int   d;
    rst = r;
    wr_valid = wv;
    load_addr = la;
    data_line = dl;
    fetch_valid = fv;
    fetch_data = fd;
    fetch_dst = fdst;
    if (r) begin
      e.wr_rdy = 1'b0;
      e.f_rdy = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      waited = 0;
      m_bad = 1'b0;
    end else begin
      fetch_turn = (waited == LIM);
      e.wr_rdy = !(fv && fetch_turn);
      e.f_rdy = !wv || fetch_turn;
      p = int'(la[7:4]);
      d = int'(la[3:0]);
      if (fv && e.f_rdy) begin
        m_regs[fdst] = fd;
      end else if (wv && e.wr_rdy) begin
        if (p == 1 || (p == 0 && d == 7)) m_regs[d] = dl[d];
        else if (p >= 2) m_bad = 1'b1;
      end
      if (fv && !e.f_rdy) waited = (waited < LIM) ? waited + 1 : waited;
      else waited = 0;
    end
    e.regs = model_line();
    e.bad = m_bad;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: readies checked mid-cycle, state checked after the edge.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        chk("wr_ready", 128'(wr_ready), 128'(cur.wr_rdy));
        chk("fetch_ready", 128'(fetch_ready), 128'(cur.f_rdy));
        @(posedge clk);
        #2;
        chk("reg_line", reg_line, cur.regs);
        chk("bad_addr", 128'(bad_addr), 128'(cur.bad));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0][7:0] dl;
    logic [15:0][7:0] ref_l;
    int               pfx;
    rst = 1'b1;
    wr_valid = 1'b0;
    load_addr = '0;
    data_line = '0;
    fetch_valid = 1'b0;
    fetch_data = '0;
    fetch_dst = '0;
    waited = 0;
    m_bad = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 0, 8'h00, '0, 0, 8'h00, 4'h0);
    cyc(1, 1, 8'h13, '1, 1, 8'hFF, 4'h3);
    chk("reset_line", reg_line, '0);
    chk("reset_bad", 128'(bad_addr), 128'd0);

    dl = rand_line();
    dl[3] = 8'hA5;
    cyc(0, 1, 8'h13, dl, 0, 8'h00, 4'h0);
    ref_l = '0;
    ref_l[3] = 8'hA5;
    chk("write_13", reg_line, ref_l);

    dl = rand_line();
    dl[7] = 8'hE3;
    cyc(0, 1, 8'h07, dl, 0, 8'h00, 4'h0);
    ref_l[7] = 8'hE3;
    chk("flag_write_07", reg_line, ref_l);

    cyc(0, 1, 8'h05, rand_line(), 0, 8'h00, 4'h0);
    chk("reserved_05", reg_line, ref_l);

    cyc(0, 1, 8'h2A, rand_line(), 0, 8'h00, 4'h0);
    chk("bad_set", 128'(bad_addr), 128'd1);
    chk("bad_no_write", reg_line, ref_l);
    dl = rand_line();
    dl[1] = 8'h5A;
    cyc(0, 1, 8'h11, dl, 0, 8'h00, 4'h0);
    chk("bad_sticky", 128'(bad_addr), 128'd1);
    cyc(1, 0, 8'h00, '0, 0, 8'h00, 4'h0);
    chk("bad_clear", 128'(bad_addr), 128'd0);

    cyc(0, 0, 8'h00, '0, 1, 8'h3C, 4'hF);
    chk("fetch_r15", 128'(reg_line[15]), 128'h3C);

    // Contention: the scoreboard checks the 4-stall / 1-grant cadence.
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, {4'h1, 4'($urandom)}, rand_line(), 1, 8'($urandom),
          4'($urandom));
    end

    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, {4'h1, 4'(i)}, rand_line(), 0, 8'h00, 4'h0);
    end
    cyc(1, 1, 8'h1F, '1, 0, 8'h00, 4'h0);
    chk("reset_after_fill", reg_line, '0);

    for (int i = 0; i < 500; i++) begin
      pfx = ($urandom_range(0, 9) < 5) ? 1 :
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : 0;
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          {4'(pfx), 4'($urandom)}, rand_line(), ($urandom_range(0, 2) != 0),
          8'($urandom), 4'($urandom));
    end
    cyc(0, 0, 8'h00, '0, 0, 8'h00, 4'h0);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
